// File: rtl/ristretto_if_dec_pipe.sv
// ----------------------------------------------------------------------------
// ristretto_if_dec_pipe
//
// Fetch-to-Decode pipeline register with a small instruction skid buffer.
// Instruction-memory responses from Fetch are presented to Decode one at a
// time. They are queued while Decode is stalled. After a redirect, responses
// that still belong to the flushed path are discarded.
//
// Parameters
//    DataWidth : width of the PC lines (32 or 64)
//    Depth     : skid buffer entries (>=1); also bounds buffered + in-flight
//
// Ports
//    clk_i             in   clock
//    rstn_i            in   asynchronous active-low reset
//    pip_fetch_req_i   in   fetch request accepted by instruction memory
//    pip_fetch_valid_i in   instruction response valid (1-cycle pulse)
//    pip_fetch_instr_i in   fetched instruction word
//    pip_fetch_pc_i    in   PC of fetched instruction
//    pip_fetch_err_i   in   bus error on this fetch
//    pip_fetch_ready_o out  fetch may issue a new request this cycle
//    pip_instr_o       out  instruction to Decode
//    pip_pc_o          out  PC to Decode
//    pip_fetch_err_o   out  fetch error flag to Decode
//    pip_new_instr_o   out  one-cycle pulse: outputs carry a new instruction
//    pip_stall_i       in   PCU stall of Decode
//    pip_flush_i       in   PCU flush (branch/exception redirect)
// ----------------------------------------------------------------------------
module ristretto_if_dec_pipe #(
   parameter int DataWidth = 32,
   parameter int Depth     = 2
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 pip_fetch_req_i,
   input  logic                 pip_fetch_valid_i,
   input  logic [31:0]          pip_fetch_instr_i,
   input  logic [DataWidth-1:0] pip_fetch_pc_i,
   input  logic                 pip_fetch_err_i,
   output logic                 pip_fetch_ready_o,
   output logic [31:0]          pip_instr_o,
   output logic [DataWidth-1:0] pip_pc_o,
   output logic                 pip_fetch_err_o,
   output logic                 pip_new_instr_o,
   input  logic                 pip_stall_i,
   input  logic                 pip_flush_i
);

   localparam int          CW        = $clog2(Depth + 1);
   localparam int          PW        = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [31:0] NOP       = 32'h00000013;
   localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(Depth);

   // skid buffer storage (data only, never reset)
   logic [31:0]          r_mem_instr [Depth];
   logic [DataWidth-1:0] r_mem_pc    [Depth];
   logic [Depth-1:0]     r_mem_err;

   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_kill_cnt;

   logic [31:0]          r_instr;
   logic [DataWidth-1:0] r_pc;
   logic                 r_err;
   logic                 r_new;

   logic w_empty;
   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_bypass;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(Depth - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   assign w_empty  = (r_count == '0);
   // a response is only kept when no old-path response is still owed
   // and the current cycle is not itself a redirect
   assign w_accept = pip_fetch_valid_i && (r_kill_cnt == '0) && !pip_flush_i;
   assign w_pop    = !pip_flush_i && !pip_stall_i && !w_empty;
   // keep ordering: once anything is queued, new arrivals go behind it
   assign w_push   = w_accept && (pip_stall_i || !w_empty);
   assign w_bypass = w_accept && !pip_stall_i && w_empty;

   // buffered plus in-flight never exceeds Depth, so the FIFO cannot overflow
   assign pip_fetch_ready_o = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_EXT;

   // ---- stage boundary: fetch response -> skid buffer ----
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_instr[r_wptr] <= pip_fetch_instr_i;
         r_mem_pc[r_wptr]    <= pip_fetch_pc_i;
         r_mem_err[r_wptr]   <= pip_fetch_err_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_kill_cnt    <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(pip_fetch_req_i) - CW'(pip_fetch_valid_i);

         // reload on every flush (never accumulate): only responses still in
         // flight after this cycle belong to the old path
         if (pip_flush_i) begin
            r_kill_cnt <= r_outstanding - CW'(pip_fetch_valid_i);
         end else if (pip_fetch_valid_i && (r_kill_cnt != '0)) begin
            r_kill_cnt <= r_kill_cnt - CW'(1);
         end

         if (pip_flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
               r_rptr <= ptr_inc(r_rptr);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   // ---- stage boundary: skid buffer / bypass -> Decode ----
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_instr <= NOP;
         r_pc    <= '0;
         r_err   <= 1'b0;
         r_new   <= 1'b0;
      end else if (pip_flush_i) begin
         // PC is left alone so Decode still sees the last valid address
         r_instr <= NOP;
         r_err   <= 1'b0;
         r_new   <= 1'b0;
      end else if (w_pop) begin
         r_instr <= r_mem_instr[r_rptr];
         r_pc    <= r_mem_pc[r_rptr];
         r_err   <= r_mem_err[r_rptr];
         r_new   <= 1'b1;
      end else if (w_bypass) begin
         r_instr <= pip_fetch_instr_i;
         r_pc    <= pip_fetch_pc_i;
         r_err   <= pip_fetch_err_i;
         r_new   <= 1'b1;
      end else begin
         r_new   <= 1'b0;
      end
   end

   assign pip_instr_o     = r_instr;
   assign pip_pc_o        = r_pc;
   assign pip_fetch_err_o = r_err;
   assign pip_new_instr_o = r_new;

endmodule

// File: tb/tb_ristretto_if_dec_pipe.sv
// ----------------------------------------------------------------------------
// tb_ristretto_if_dec_pipe
//
// Directed bench for the Fetch-to-Decode skid buffer (DataWidth=32, Depth=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, i.e. they show the effect of the preceding edge.
// ----------------------------------------------------------------------------
module tb_ristretto_if_dec_pipe;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        pip_fetch_req_i;
   logic        pip_fetch_valid_i;
   logic [31:0] pip_fetch_instr_i;
   logic [31:0] pip_fetch_pc_i;
   logic        pip_fetch_err_i;
   logic        pip_fetch_ready_o;
   logic [31:0] pip_instr_o;
   logic [31:0] pip_pc_o;
   logic        pip_fetch_err_o;
   logic        pip_new_instr_o;
   logic        pip_stall_i;
   logic        pip_flush_i;

   int errors = 0;
   int checks = 0;

   ristretto_if_dec_pipe #(
      .DataWidth(32),
      .Depth(2)
   ) dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .pip_fetch_req_i  (pip_fetch_req_i),
      .pip_fetch_valid_i(pip_fetch_valid_i),
      .pip_fetch_instr_i(pip_fetch_instr_i),
      .pip_fetch_pc_i   (pip_fetch_pc_i),
      .pip_fetch_err_i  (pip_fetch_err_i),
      .pip_fetch_ready_o(pip_fetch_ready_o),
      .pip_instr_o      (pip_instr_o),
      .pip_pc_o         (pip_pc_o),
      .pip_fetch_err_o  (pip_fetch_err_o),
      .pip_new_instr_o  (pip_new_instr_o),
      .pip_stall_i      (pip_stall_i),
      .pip_flush_i      (pip_flush_i)
   );

   always #5 clk_i = ~clk_i;

   // Fetch must never issue a request while the buffer reports not ready.
   always @(negedge clk_i) begin
      if (rstn_i && pip_fetch_req_i) begin
         checks++;
         if (pip_fetch_ready_o !== 1'b1) begin
            $display("FAIL protocol_req_while_not_ready: ready=%b required 1 at %0t", pip_fetch_ready_o, $time);
            errors++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation still running at %0t, required finished", $time);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic req, input logic vld, input logic [31:0] instr,
                        input logic [31:0] pc, input logic err);
      pip_fetch_req_i   = req;
      pip_fetch_valid_i = vld;
      pip_fetch_instr_i = instr;
      pip_fetch_pc_i    = pc;
      pip_fetch_err_i   = err;
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      pip_stall_i = 1'b0;
      pip_flush_i = 1'b0;
      drive(0, 0, 32'h0, 32'h0, 0);
      tick();
      tick();
      if (pip_instr_o !== 32'h00000013) begin $display("FAIL reset_instr: got %h required %h", pip_instr_o, 32'h00000013); errors++; end checks++;
      if (pip_pc_o !== 32'h0) begin $display("FAIL reset_pc: got %h required %h", pip_pc_o, 32'h0); errors++; end checks++;
      if (pip_fetch_err_o !== 1'b0) begin $display("FAIL reset_err: got %b required 0", pip_fetch_err_o); errors++; end checks++;
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL reset_new: got %b required 0", pip_new_instr_o); errors++; end checks++;
      if (pip_fetch_ready_o !== 1'b1) begin $display("FAIL reset_ready: got %b required 1", pip_fetch_ready_o); errors++; end checks++;
      rstn_i = 1'b1;
      tick();
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL reset_release_new: got %b required 0", pip_new_instr_o); errors++; end checks++;
   endtask

   task automatic test_bypass();
      drive(1, 0, 32'h0, 32'h0, 0);
      tick();
      drive(0, 1, 32'h00500093, 32'h100, 0);
      tick();
      drive(0, 0, 32'h0, 32'h0, 0);
      if (pip_instr_o !== 32'h00500093) begin $display("FAIL bypass_instr: got %h required %h", pip_instr_o, 32'h00500093); errors++; end checks++;
      if (pip_pc_o !== 32'h100) begin $display("FAIL bypass_pc: got %h required %h", pip_pc_o, 32'h100); errors++; end checks++;
      if (pip_new_instr_o !== 1'b1) begin $display("FAIL bypass_new: got %b required 1", pip_new_instr_o); errors++; end checks++;
      tick();
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL bypass_new_clear: got %b required 0", pip_new_instr_o); errors++; end checks++;
      if (pip_instr_o !== 32'h00500093) begin $display("FAIL bypass_hold: got %h required %h", pip_instr_o, 32'h00500093); errors++; end checks++;
   endtask

   task automatic test_stall();
      drive(1, 0, 32'h0, 32'h0, 0);
      tick();
      pip_stall_i = 1'b1;
      drive(1, 0, 32'h0, 32'h0, 0);
      tick();
      drive(0, 1, 32'h00100113, 32'h104, 0);
      tick();
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL stall_new_1: got %b required 0", pip_new_instr_o); errors++; end checks++;
      drive(0, 1, 32'h00200193, 32'h108, 0);
      tick();
      drive(0, 0, 32'h0, 32'h0, 0);
      if (pip_instr_o !== 32'h00500093) begin $display("FAIL stall_hold_instr: got %h required %h", pip_instr_o, 32'h00500093); errors++; end checks++;
      if (pip_pc_o !== 32'h100) begin $display("FAIL stall_hold_pc: got %h required %h", pip_pc_o, 32'h100); errors++; end checks++;
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL stall_new_2: got %b required 0", pip_new_instr_o); errors++; end checks++;
      if (dut.r_count !== 2'd2) begin $display("FAIL stall_count: got %0d required 2", dut.r_count); errors++; end checks++;
      if (pip_fetch_ready_o !== 1'b0) begin $display("FAIL stall_ready: got %b required 0", pip_fetch_ready_o); errors++; end checks++;
      pip_stall_i = 1'b0;
      tick();
      if (pip_pc_o !== 32'h104) begin $display("FAIL unstall_pc_1: got %h required %h", pip_pc_o, 32'h104); errors++; end checks++;
      if (pip_instr_o !== 32'h00100113) begin $display("FAIL unstall_instr_1: got %h required %h", pip_instr_o, 32'h00100113); errors++; end checks++;
      if (pip_new_instr_o !== 1'b1) begin $display("FAIL unstall_new_1: got %b required 1", pip_new_instr_o); errors++; end checks++;
      tick();
      if (pip_pc_o !== 32'h108) begin $display("FAIL unstall_pc_2: got %h required %h", pip_pc_o, 32'h108); errors++; end checks++;
      if (pip_instr_o !== 32'h00200193) begin $display("FAIL unstall_instr_2: got %h required %h", pip_instr_o, 32'h00200193); errors++; end checks++;
      if (pip_new_instr_o !== 1'b1) begin $display("FAIL unstall_new_2: got %b required 1", pip_new_instr_o); errors++; end checks++;
      tick();
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL unstall_new_clear: got %b required 0", pip_new_instr_o); errors++; end checks++;
      if (pip_fetch_ready_o !== 1'b1) begin $display("FAIL unstall_ready: got %b required 1", pip_fetch_ready_o); errors++; end checks++;
   endtask

   task automatic test_flush_kill();
      drive(1, 0, 32'h0, 32'h0, 0);
      tick();
      tick();
      drive(0, 0, 32'h0, 32'h0, 0);
      if (pip_fetch_ready_o !== 1'b0) begin $display("FAIL flush_pre_ready: got %b required 0", pip_fetch_ready_o); errors++; end checks++;
      pip_flush_i = 1'b1;
      tick();
      pip_flush_i = 1'b0;
      if (pip_instr_o !== 32'h00000013) begin $display("FAIL flush_instr: got %h required %h", pip_instr_o, 32'h00000013); errors++; end checks++;
      if (pip_pc_o !== 32'h108) begin $display("FAIL flush_pc_hold: got %h required %h", pip_pc_o, 32'h108); errors++; end checks++;
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL flush_new: got %b required 0", pip_new_instr_o); errors++; end checks++;
      if (dut.r_count !== 2'd0) begin $display("FAIL flush_count: got %0d required 0", dut.r_count); errors++; end checks++;
      if (dut.r_kill_cnt !== 2'd2) begin $display("FAIL flush_kill: got %0d required 2", dut.r_kill_cnt); errors++; end checks++;
      drive(0, 1, 32'hBAD00001, 32'h300, 0);
      tick();
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL kill_drop_1: got %b required 0", pip_new_instr_o); errors++; end checks++;
      drive(0, 1, 32'hBAD00002, 32'h304, 0);
      tick();
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL kill_drop_2: got %b required 0", pip_new_instr_o); errors++; end checks++;
      if (pip_instr_o !== 32'h00000013) begin $display("FAIL kill_drop_instr: got %h required %h", pip_instr_o, 32'h00000013); errors++; end checks++;
      if (dut.r_kill_cnt !== 2'd0) begin $display("FAIL kill_done: got %0d required 0", dut.r_kill_cnt); errors++; end checks++;
      drive(1, 0, 32'h0, 32'h0, 0);
      tick();
      drive(0, 1, 32'h00000517, 32'h200, 0);
      tick();
      drive(0, 0, 32'h0, 32'h0, 0);
      if (pip_pc_o !== 32'h200) begin $display("FAIL newpath_pc: got %h required %h", pip_pc_o, 32'h200); errors++; end checks++;
      if (pip_instr_o !== 32'h00000517) begin $display("FAIL newpath_instr: got %h required %h", pip_instr_o, 32'h00000517); errors++; end checks++;
      if (pip_new_instr_o !== 1'b1) begin $display("FAIL newpath_new: got %b required 1", pip_new_instr_o); errors++; end checks++;
      tick();
   endtask

   task automatic test_flush_with_valid();
      drive(1, 0, 32'h0, 32'h0, 0);
      tick();
      // flush, old response and a new-path request all in the same cycle
      pip_flush_i = 1'b1;
      drive(1, 1, 32'hBAD00003, 32'h308, 0);
      tick();
      pip_flush_i = 1'b0;
      drive(0, 0, 32'h0, 32'h0, 0);
      if (dut.r_kill_cnt !== 2'd0) begin $display("FAIL flushvld_kill: got %0d required 0", dut.r_kill_cnt); errors++; end checks++;
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL flushvld_new: got %b required 0", pip_new_instr_o); errors++; end checks++;
      if (pip_instr_o !== 32'h00000013) begin $display("FAIL flushvld_instr: got %h required %h", pip_instr_o, 32'h00000013); errors++; end checks++;
      if (pip_pc_o !== 32'h200) begin $display("FAIL flushvld_pc_hold: got %h required %h", pip_pc_o, 32'h200); errors++; end checks++;
      tick();
      drive(0, 1, 32'h00400213, 32'h204, 0);
      tick();
      drive(0, 0, 32'h0, 32'h0, 0);
      if (pip_pc_o !== 32'h204) begin $display("FAIL flushvld_newpath_pc: got %h required %h", pip_pc_o, 32'h204); errors++; end checks++;
      if (pip_new_instr_o !== 1'b1) begin $display("FAIL flushvld_newpath_new: got %b required 1", pip_new_instr_o); errors++; end checks++;
      tick();
   endtask

   task automatic test_err_path();
      pip_stall_i = 1'b1;
      drive(1, 0, 32'h0, 32'h0, 0);
      tick();
      tick();
      drive(0, 1, 32'h00000033, 32'h300, 0);
      tick();
      drive(0, 1, 32'h0000006F, 32'h304, 1);
      tick();
      drive(0, 0, 32'h0, 32'h0, 0);
      if (pip_fetch_err_o !== 1'b0) begin $display("FAIL err_stalled: got %b required 0", pip_fetch_err_o); errors++; end checks++;
      pip_stall_i = 1'b0;
      tick();
      if (pip_pc_o !== 32'h300) begin $display("FAIL err_first_pc: got %h required %h", pip_pc_o, 32'h300); errors++; end checks++;
      if (pip_fetch_err_o !== 1'b0) begin $display("FAIL err_first_flag: got %b required 0", pip_fetch_err_o); errors++; end checks++;
      tick();
      if (pip_pc_o !== 32'h304) begin $display("FAIL err_second_pc: got %h required %h", pip_pc_o, 32'h304); errors++; end checks++;
      if (pip_fetch_err_o !== 1'b1) begin $display("FAIL err_second_flag: got %b required 1", pip_fetch_err_o); errors++; end checks++;
      if (pip_new_instr_o !== 1'b1) begin $display("FAIL err_second_new: got %b required 1", pip_new_instr_o); errors++; end checks++;
      tick();
   endtask

   task automatic test_async_reset();
      pip_stall_i = 1'b1;
      drive(1, 0, 32'h0, 32'h0, 0);
      tick();
      tick();
      drive(0, 1, 32'h00700393, 32'h400, 0);
      tick();
      drive(0, 1, 32'h00800413, 32'h404, 0);
      tick();
      drive(0, 0, 32'h0, 32'h0, 0);
      if (dut.r_count !== 2'd2) begin $display("FAIL areset_pre_count: got %0d required 2", dut.r_count); errors++; end checks++;
      #3;
      rstn_i = 1'b0;
      #1;
      if (pip_instr_o !== 32'h00000013) begin $display("FAIL areset_instr: got %h required %h", pip_instr_o, 32'h00000013); errors++; end checks++;
      if (pip_pc_o !== 32'h0) begin $display("FAIL areset_pc: got %h required %h", pip_pc_o, 32'h0); errors++; end checks++;
      if (pip_fetch_err_o !== 1'b0) begin $display("FAIL areset_err: got %b required 0", pip_fetch_err_o); errors++; end checks++;
      if (dut.r_count !== 2'd0) begin $display("FAIL areset_count: got %0d required 0", dut.r_count); errors++; end checks++;
      pip_stall_i = 1'b0;
      #2;
      rstn_i = 1'b1;
      tick();
      if (pip_fetch_ready_o !== 1'b1) begin $display("FAIL areset_ready: got %b required 1", pip_fetch_ready_o); errors++; end checks++;
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL areset_new_1: got %b required 0", pip_new_instr_o); errors++; end checks++;
      tick();
      if (pip_new_instr_o !== 1'b0) begin $display("FAIL areset_new_2: got %b required 0", pip_new_instr_o); errors++; end checks++;
      if (pip_instr_o !== 32'h00000013) begin $display("FAIL areset_instr_after: got %h required %h", pip_instr_o, 32'h00000013); errors++; end checks++;
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_stall();
      test_flush_kill();
      test_flush_with_valid();
      test_err_path();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ristretto_if_dec_pipe.md
Name: ristretto_if_dec_pipe

Overview:
Fetch-to-Decode pipeline register with a small instruction skid buffer, directly upstream of the Decode stage.
- Accepts instruction-memory responses from the Fetch stage.
- Queues them while the Pipeline Control Unit stalls decode.
- Presents one instruction at a time to Decode, marked by a one-cycle new-instruction pulse.
- Tracks in-flight fetch requests, so responses belonging to a flushed path are discarded.

Parameters:
DataWidth, 32, width of PC lines (32 or 64)
Depth, 2, skid buffer entries (>=1); also the bound on buffered plus in-flight fetches

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; one clock; reset is asynchronous and active-low
pip_fetch_req_i  in  1  fetch request accepted by instruction memory this cycle
pip_fetch_valid_i  in  1  instruction response valid (1-cycle pulse per response)
pip_fetch_instr_i  in  32  fetched instruction word
pip_fetch_pc_i  in  DataWidth  PC of fetched instruction
pip_fetch_err_i  in  1  bus error on this fetch
pip_fetch_ready_o  out  1  fetch may issue a new request this cycle
pip_instr_o  out  32  instruction to Decode
pip_pc_o  out  DataWidth  PC to Decode
pip_fetch_err_o  out  1  fetch error flag to Decode
pip_new_instr_o  out  1  one-cycle pulse: outputs carry a new instruction
pip_stall_i  in  1  PCU stall of Decode
pip_flush_i  in  1  PCU flush (branch/exception redirect)

Behaviour:
- Reset values (async, rstn_i low):
  - pip_instr_o=32'h00000013 (NOP); pip_pc_o=0; pip_fetch_err_o=0; pip_new_instr_o=0.
  - FIFO count, outstanding counter and kill counter = 0.
  - Reset mid-operation drops all queued and in-flight state immediately.
- Accepted response: pip_fetch_valid_i && kill_cnt==0. Dropped response: pip_fetch_valid_i && kill_cnt>0; kill_cnt decrements by 1.
- Outstanding counter: next = outstanding + pip_fetch_req_i - pip_fetch_valid_i, applied every cycle, including flush cycles and cycles with dropped responses.
- pip_fetch_ready_o = (count + outstanding) < Depth. This is combinational from registers only and guarantees the FIFO never overflows.
- Fetch issuing a request while ready=0 is a protocol violation. The bench asserts it never happens; RTL behaviour in that case is undefined.
- Normal cycle (no stall, no flush):
  - If FIFO non-empty: pop head into the output registers and set new_instr_o=1. An accepted response this cycle is pushed to the tail.
  - If FIFO empty and an accepted response arrives: bypass it straight into the output registers, new_instr_o=1 next cycle (latency 1).
  - Otherwise: outputs hold, new_instr_o=0.
- Stall cycle (stall=1, flush=0): output registers hold, new_instr_o=0, an accepted response is pushed to the FIFO. The pulse never repeats across a stall.
- Flush cycle (flush=1; wins over stall):
  - FIFO cleared.
  - pip_instr_o=NOP, pip_fetch_err_o=0, pip_pc_o holds, new_instr_o=0.
  - Any response arriving this cycle is dropped.
  - kill_cnt <= outstanding - pip_fetch_valid_i, i.e. old-path responses still in flight.
  - A pip_fetch_req_i in the flush cycle belongs to the new path and is not killed.
- Flush while kill_cnt>0: kill_cnt is reloaded with the same rule, never accumulated.
- FIFO:
  - Circular buffer, read/write pointers wrap modulo Depth.
  - count width $clog2(Depth+1).
  - Simultaneous push and pop at full is impossible given the ready rule. At count==Depth only a pop can occur.
- pip_fetch_err_o travels with its instruction through the FIFO and bypass path.

Test Plan:
- Reset, then valid with instr=32'h00500093, pc=0x100, no stall: next cycle instr_o=0x00500093, pc_o=0x100, new_instr_o=1 for exactly 1 cycle, then 0.
- Stall 3 cycles; two responses (pc 0x104, 0x108) arrive during the stall: outputs hold, new_instr_o=0, count=2, ready_o=0. Release stall: 0x104 is presented next cycle, 0x108 the cycle after, one pulse each.
- Two requests outstanding (ready_o=0), then flush: next cycle instr_o=0x00000013, new_instr_o=0, count=0, kill_cnt=2. Both following responses dropped with no pulse. The third response (new-path pc 0x200) is presented.
- Flush and valid in the same cycle with outstanding=1: the response is dropped and kill_cnt=0. A new-path response two cycles later is presented with a pulse.
- Response with fetch_err_i=1 queued behind one stalled entry: fetch_err_o=1 only when that entry pops. The entry ahead shows err=0.
- Assert rstn_i low asynchronously mid-cycle with count=2: outputs return to reset values immediately, ready_o=1 after release, and no pulse occurs.
